// File: rtl/imem_loader_pkg.sv
// Shared constants for the LEGv8 instruction-memory loader: FSM encodings and
// byte-lane geometry.
package imem_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LANE_W         = 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERROR = 3'd4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the instruction-memory loader.
interface imem_loader_if;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_last;
  logic       byte_ready;

  modport master (output byte_valid, byte_data, byte_last, input byte_ready);
  modport slave  (input byte_valid, byte_data, byte_last, output byte_ready);

endinterface

// File: rtl/imem_loader_word_packer.sv
// Packs accepted bytes little-endian into a word; emits a one-cycle word_valid
// when lane 3 fills or a last byte arrives, with unfilled upper lanes zero.
module word_packer
  import imem_loader_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        data,
  input  logic              last,
  output logic              completing,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [LANE_W-1:0] lane;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] merged;

  always_comb begin
    merged     = acc | (WORD_W'(data) << {lane, 3'b000});
    completing = accept && ((lane == LANE_W'(BYTES_PER_WORD - 1)) || last);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane       <= '0;
      acc        <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        lane <= '0;
        acc  <= '0;
      end else if (accept) begin
        if (completing) begin
          word       <= merged;
          word_valid <= 1'b1;
          lane       <= '0;
          acc        <= '0;
        end else begin
          acc  <= merged;
          lane <= lane + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Writer side of the LEGv8 instruction memory: streams bytes into sequential
// imem words from word 0 and holds the CPU in reset until loading completes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  imem_loader_if.slave      bus,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err_overflow,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [2:0] state;
  logic [2:0] state_nx;
  logic       has_room;
  logic       accept;
  logic       completing;
  logic       clear;

  always_comb begin
    has_room = (words_loaded < DEPTH);
    accept   = bus.byte_valid && bus.byte_ready;
    clear    = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
  end

  assign bus.byte_ready = (state == ST_LOAD) && has_room;
  assign done           = (state == ST_DONE);
  assign cpu_rst        = (state != ST_DONE);
  assign err_overflow   = (state == ST_ERROR);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_LOAD;
      // A full memory refuses the byte, so last-on-final-word still reaches FLUSH.
      ST_LOAD: begin
        if (accept && bus.byte_last)         state_nx = ST_FLUSH;
        else if (!has_room && bus.byte_valid) state_nx = ST_ERROR;
      end
      ST_FLUSH: state_nx = ST_DONE;
      ST_DONE:  if (start) state_nx = ST_LOAD;
      ST_ERROR: if (start) state_nx = ST_LOAD;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      words_loaded <= '0;
      imem_waddr   <= '0;
    end else begin
      state <= state_nx;
      if (clear) begin
        words_loaded <= '0;
      end else if (completing) begin
        imem_waddr   <= words_loaded[ADDR_W-1:0];
        words_loaded <= words_loaded + 1'b1;
      end
    end
  end

  word_packer #(.WORD_W(WORD_W)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .accept     (accept),
    .data       (bus.byte_data),
    .last       (bus.byte_last),
    .completing (completing),
    .word_valid (imem_we),
    .word       (imem_wdata)
  );

endmodule
